// File: rtl/mod_down_counter.sv
// Modular down counter: counts MAX..1 and wraps to MAX, with a validated parallel load,
// a wrap pulse and a saturating wrap tally. Define MOD_DOWN_COUNTER_ASSERT_EN for embedded checks.
module mod_down_counter #(
    parameter int unsigned WIDTH   = 11,
    parameter int unsigned MAX     = 500,
    parameter int unsigned TALLY_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_selector,
    input  logic               i_load,
    input  logic [WIDTH-1:0]   i_load_val,
    output logic [WIDTH-1:0]   o_c,
    output logic               o_active,
    output logic               o_wrap,
    output logic [TALLY_W-1:0] o_wrap_cnt,
    output logic               o_load_err
);

    localparam logic [WIDTH-1:0]   MAX_V     = WIDTH'(MAX);
    localparam logic [WIDTH-1:0]   ONE_V     = WIDTH'(1);
    localparam logic [TALLY_W-1:0] TALLY_MAX = '1;

    typedef enum logic {StIdle, StCount} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [WIDTH-1:0]   r_c;
    logic               r_wrap;
    logic [TALLY_W-1:0] r_wrap_cnt;
    logic               r_load_err;

    logic w_load_ok;
    logic w_load_bad;
    logic w_step;
    logic w_at_one;

    // A rejected load still owns the cycle, so selector is masked by any load request.
    assign w_load_ok  = i_load && (i_load_val != '0) && (i_load_val <= MAX_V);
    assign w_load_bad = i_load && !w_load_ok;
    assign w_step     = !i_load && i_selector;
    assign w_at_one   = (r_c == ONE_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_load_ok || w_step) begin
            w_state_next = StCount;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c        <= MAX_V;
            r_wrap     <= 1'b0;
            r_wrap_cnt <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= 1'b0;
            r_load_err <= w_load_bad;
            if (w_load_ok) begin
                r_c <= i_load_val;
            end else if (w_step) begin
                if (w_at_one) begin
                    r_c    <= MAX_V;
                    r_wrap <= 1'b1;
                    if (r_wrap_cnt != TALLY_MAX) begin
                        r_wrap_cnt <= r_wrap_cnt + 1'b1;
                    end
                end else begin
                    r_c <= r_c - 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_active   = (r_state == StCount);
        o_c        = r_c;
        o_wrap     = r_wrap;
        o_wrap_cnt = r_wrap_cnt;
        o_load_err = r_load_err;
    end

`ifdef MOD_DOWN_COUNTER_ASSERT_EN
    a_c_range: assert property (@(posedge clk) disable iff (rst)
        (r_c != '0) && (r_c <= MAX_V));
    a_wrap_max: assert property (@(posedge clk) disable iff (rst)
        r_wrap |-> (r_c == MAX_V));
    a_wrap_err_excl: assert property (@(posedge clk) disable iff (rst)
        !(r_wrap && r_load_err));
    // First cycle out of reset compares against a pre-reset sample, so skip it.
    a_tally_mono: assert property (@(posedge clk) disable iff (rst)
        !$past(rst) |-> (r_wrap_cnt >= $past(r_wrap_cnt)));
    a_active_sticky: assert property (@(posedge clk) disable iff (rst)
        (!$past(rst) && $past(r_state == StCount)) |-> (r_state == StCount));
`endif

endmodule
